// File: rtl/sat_pkg.sv
// +-------------------------------------------------------------------------+
// | sat_pkg : shared math helpers, state encodings and mask layout, rev 1.0  |
// +-------------------------------------------------------------------------+
`default_nettype none

package sat_pkg;

   // Ceiling log2, never below 1 so it can size a port directly.
   function automatic int log2c(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int log2f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) <= v) r = i;
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      DONE = 2'd1,
      ERR  = 2'd2
   } state_t;

   // Clause i occupies bits [mask_lsb(i, N) +: N] of each packed mask.
   function automatic int mask_lsb(input int clause, input int stride);
      return clause * stride;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lit_decoder.sv
// +-------------------------------------------------------------------------+
// | lit_decoder : one-hot decode of a variable index with range flag, rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module lit_decoder
   import sat_pkg::*;
#(
   parameter int N  = 32,
   parameter int VW = log2c(N)
) (
   input  logic [VW-1:0] var_idx,
   output logic [N-1:0]  onehot,
   output logic          out_of_range
);

   // Compare rather than index so a non-power-of-two N never selects past the vector.
   always_comb begin
      out_of_range = (32'(var_idx) >= 32'(N));
      onehot       = '0;
      for (int i = 0; i < N; i++) begin
         if (32'(var_idx) == 32'(i)) onehot[i] = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cnf_loader.sv
// +-------------------------------------------------------------------------+
// | cnf_loader : streams CNF literals into per-clause pos/neg masks, rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module cnf_loader
   import sat_pkg::*;
#(
   parameter int N  = 32,
   parameter int M  = 4,
   parameter int K  = 3,
   parameter int VW = log2c(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 lit_valid,
   output logic                 lit_ready,
   input  logic [VW-1:0]        lit_var,
   input  logic                 lit_neg,
   input  logic                 lit_eoc,
   input  logic                 lit_eof,
   output logic [N*M-1:0]       pos_mask,
   output logic [N*M-1:0]       neg_mask,
   output logic [M-1:0]         clause_valid,
   output logic [log2c(M):0]    clause_count,
   output logic                 loaded,
   output logic                 error
);

   localparam int CW = log2c(M) + 1;
   localparam int LW = log2c(K + 1);

   state_t          state;
   logic [CW-1:0]   cur;
   logic [LW-1:0]   lit_cnt;
   logic [N-1:0]    onehot;
   logic            oor;
   logic            accept;
   logic            close;
   logic            bad;
   logic [M-1:0]    clause_sel;

   lit_decoder #(.N(N), .VW(VW)) u_dec (
      .var_idx      (lit_var),
      .onehot       (onehot),
      .out_of_range (oor)
   );

   assign lit_ready    = (state == LOAD) & ~clear;
   assign accept       = lit_valid & lit_ready;
   assign close        = lit_eoc | lit_eof;
   assign bad          = oor | (lit_cnt == LW'(K)) | (cur == CW'(M));
   assign clause_count = cur;

   // cur == M leaves every enable low, so an overflow beat can never write a slot.
   always_comb begin
      clause_sel = '0;
      for (int i = 0; i < M; i++) begin
         clause_sel[i] = (cur == CW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset | clear) begin
         state        <= LOAD;
         pos_mask     <= '0;
         neg_mask     <= '0;
         clause_valid <= '0;
         cur          <= '0;
         lit_cnt      <= '0;
         loaded       <= 1'b0;
         error        <= 1'b0;
      end else if (accept) begin
         if (bad) begin
            state <= ERR;
            error <= 1'b1;
         end else begin
            for (int i = 0; i < M; i++) begin
               if (clause_sel[i]) begin
                  if (lit_neg)
                     neg_mask[mask_lsb(i, N) +: N] <= neg_mask[mask_lsb(i, N) +: N] | onehot;
                  else
                     pos_mask[mask_lsb(i, N) +: N] <= pos_mask[mask_lsb(i, N) +: N] | onehot;
               end
            end
            if (close) begin
               clause_valid <= clause_valid | clause_sel;
               cur          <= cur + 1'b1;
               lit_cnt      <= '0;
            end else begin
               lit_cnt <= lit_cnt + 1'b1;
            end
            if (lit_eof) begin
               state  <= DONE;
               loaded <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cnf_loader.sv
// +-------------------------------------------------------------------------+
// | tb_cnf_loader : scoreboard bench for cnf_loader (N=4, M=4, K=3), rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_cnf_loader;

   localparam int N  = 4;
   localparam int M  = 4;
   localparam int K  = 3;
   localparam int VW = 2;

   logic          clk;
   logic          reset;
   logic          clear;
   logic          lit_valid;
   logic          lit_ready;
   logic [VW-1:0] lit_var;
   logic          lit_neg;
   logic          lit_eoc;
   logic          lit_eof;
   logic [15:0]   pos_mask;
   logic [15:0]   neg_mask;
   logic [3:0]    clause_valid;
   logic [2:0]    clause_count;
   logic          loaded;
   logic          error;

   typedef struct {
      logic [15:0] pos;
      logic [15:0] neg;
      logic [3:0]  cv;
      logic [2:0]  cc;
      logic        ld;
      logic        er;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic prev_ld = 1'b0;
   logic prev_er = 1'b0;

   cnf_loader #(.N(N), .M(M), .K(K), .VW(VW)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .lit_valid    (lit_valid),
      .lit_ready    (lit_ready),
      .lit_var      (lit_var),
      .lit_neg      (lit_neg),
      .lit_eoc      (lit_eoc),
      .lit_eof      (lit_eof),
      .pos_mask     (pos_mask),
      .neg_mask     (neg_mask),
      .clause_valid (clause_valid),
      .clause_count (clause_count),
      .loaded       (loaded),
      .error        (error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: each rising loaded or error is a completed transaction.
   always @(negedge clk) begin
      exp_t e;
      if ((loaded && !prev_ld) || (error && !prev_er)) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_unexpected: loaded=%0b error=%0b with empty scoreboard", loaded, error);
         end else begin
            e = exp_q.pop_front();
            chk("mon_pos_mask",     32'(pos_mask),     32'(e.pos));
            chk("mon_neg_mask",     32'(neg_mask),     32'(e.neg));
            chk("mon_clause_valid", 32'(clause_valid), 32'(e.cv));
            chk("mon_clause_count", 32'(clause_count), 32'(e.cc));
            chk("mon_loaded",       32'(loaded),       32'(e.ld));
            chk("mon_error",        32'(error),        32'(e.er));
         end
      end
      prev_ld = loaded;
      prev_er = error;
   end

   function automatic exp_t mk(input logic [15:0] p, input logic [15:0] n, input logic [3:0] cv,
                               input logic [2:0] cc, input logic ld, input logic er);
      exp_t e;
      e.pos = p; e.neg = n; e.cv = cv; e.cc = cc; e.ld = ld; e.er = er;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic beat(input int v, input bit ng, input bit eoc, input bit eof);
      int n;
      n = 0;
      lit_valid = 1'b1; lit_var = VW'(v); lit_neg = ng; lit_eoc = eoc; lit_eof = eof;
      #1;
      while (!lit_ready && n < 20) begin
         @(negedge clk); n++;
      end
      if (!lit_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat_timeout: lit_ready=%0b required 1 within 20 cycles", lit_ready);
      end
      @(negedge clk);
      lit_valid = 1'b0; lit_eoc = 1'b0; lit_eof = 1'b0;
   endtask

   task automatic beat_bp(input int v, input bit ng, input bit eoc, input bit eof);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      beat(v, ng, eoc, eof);
   endtask

   // (x0|x1|~x2)(~x0|x3)(x2)(~x1|~x3|x0)
   task automatic nominal(input bit eof);
      beat(0, 0, 0, 0); beat(1, 0, 0, 0); beat(2, 1, 1, 0);
      beat(0, 1, 0, 0); beat(3, 0, 1, 0);
      beat(2, 0, 1, 0);
      beat(1, 1, 0, 0); beat(3, 1, 0, 0); beat(0, 0, 1, eof);
   endtask

   task automatic pulse(input bit is_reset);
      if (is_reset) reset = 1'b1; else clear = 1'b1;
      @(negedge clk);
      reset = 1'b0; clear = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      #1;
      chk({tag, "_pos"},   32'(pos_mask),     32'h0);
      chk({tag, "_neg"},   32'(neg_mask),     32'h0);
      chk({tag, "_cv"},    32'(clause_valid), 32'h0);
      chk({tag, "_cc"},    32'(clause_count), 32'h0);
      chk({tag, "_ld"},    32'(loaded),       32'h0);
      chk({tag, "_er"},    32'(error),        32'h0);
      chk({tag, "_ready"}, 32'(lit_ready),    32'h1);
   endtask

   initial begin
      int w;
      reset = 1'b1; clear = 1'b0; lit_valid = 1'b0;
      lit_var = '0; lit_neg = 1'b0; lit_eoc = 1'b0; lit_eof = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset("rst0");

      // Nominal formula
      exp_q.push_back(mk(16'h1483, 16'hA014, 4'hF, 3'd4, 1'b1, 1'b0));
      nominal(1'b1);
      chk("nom_loaded", 32'(loaded), 32'h1);
      chk("nom_ready_low", 32'(lit_ready), 32'h0);
      lit_valid = 1'b1; lit_var = 2'd1; lit_neg = 1'b1;
      @(negedge clk);
      lit_valid = 1'b0;
      chk("done_hold_pos", 32'(pos_mask), 32'h1483);
      chk("done_hold_neg", 32'(neg_mask), 32'hA014);

      // Reset from DONE, then short formula (x1|~x0)(x3)
      pulse(1'b1);
      check_reset("rst_done");
      exp_q.push_back(mk(16'h0082, 16'h0001, 4'b0011, 3'd2, 1'b1, 1'b0));
      beat(1, 0, 0, 0); beat(0, 1, 1, 0); beat(3, 0, 1, 1);
      chk("short_upper_pos", 32'(pos_mask[15:8]), 32'h0);

      // Too many literals
      pulse(1'b0);
      chk("clr_pos", 32'(pos_mask), 32'h0);
      exp_q.push_back(mk(16'h0007, 16'h0000, 4'h0, 3'd0, 1'b0, 1'b1));
      beat(0, 0, 0, 0); beat(1, 0, 0, 0); beat(2, 0, 0, 0); beat(3, 0, 0, 0);
      chk("k_err", 32'(error), 32'h1);
      chk("k_ready_low", 32'(lit_ready), 32'h0);
      chk("k_loaded", 32'(loaded), 32'h0);
      chk("k_bit3_clear", 32'(pos_mask[3]), 32'h0);

      // Reset from ERR, then too many clauses
      pulse(1'b1);
      check_reset("rst_err");
      exp_q.push_back(mk(16'h1483, 16'hA014, 4'hF, 3'd4, 1'b0, 1'b1));
      nominal(1'b0);
      beat(1, 0, 1, 0);
      chk("m_err", 32'(error), 32'h1);
      chk("m_pos_kept", 32'(pos_mask), 32'h1483);

      // Backpressure: (x3|~x1)(~x2|x0|x2)(x1)
      pulse(1'b0);
      exp_q.push_back(mk(16'h0258, 16'h0042, 4'b0111, 3'd3, 1'b1, 1'b0));
      beat_bp(3, 0, 0, 0); beat_bp(1, 1, 1, 0);
      beat_bp(2, 1, 0, 0); beat_bp(0, 0, 0, 0); beat_bp(2, 0, 1, 0);
      beat_bp(1, 0, 1, 1);
      chk("bp_loaded", 32'(loaded), 32'h1);

      // Clear concurrent with a valid beat
      pulse(1'b0);
      beat(0, 0, 0, 0);
      chk("clrv_pre_pos", 32'(pos_mask), 32'h1);
      lit_valid = 1'b1; lit_var = 2'd2; lit_neg = 1'b0; clear = 1'b1;
      #1;
      chk("clrv_ready_low", 32'(lit_ready), 32'h0);
      @(negedge clk);
      clear = 1'b0; lit_valid = 1'b0;
      #1;
      chk("clrv_pos", 32'(pos_mask), 32'h0);
      chk("clrv_neg", 32'(neg_mask), 32'h0);
      chk("clrv_cc", 32'(clause_count), 32'h0);
      chk("clrv_ready", 32'(lit_ready), 32'h1);

      w = 0;
      while (exp_q.size() != 0 && w < 10) begin
         @(negedge clk); w++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
